cpu_bus_cycle_ctrl: RTL and testbench
=====================================

Name: cpu_bus_cycle_ctrl

Overview:
- Sequences SDMAC DMA-master cycles on the 68030 bus.
- Arbitrates for the bus (BR_/BG_/BGACK_) and drives AS_/DS_/R_W.
- Terminates each cycle on STERM_ (synchronous), DSACK_[1:0] (asynchronous) or BERR_; splits a longword into two word cycles when a 16-bit port responds.
- Sits between the DMA FIFO engine, which issues runs of longword transfers, and the CPU-side bus pins. The termination inputs are the same ones the CPU state machine next-state terms consume.

Parameters:
TIMEOUT_CYC, 64, clocks in WAIT without termination before a forced bus error (2..255).

Ports:
CLK  in  1  bus-side state machine clock
RST  in  1  synchronous, active-high reset
DMA_REQ  in  1  DMA engine requests a run; level, held for the whole run
XFER_CNT  in  4  longwords in the run; sampled in IDLE; 0 = no request
DIR_RD  in  1  1 = bus read (memory to FIFO); sampled with XFER_CNT
BG_  in  1  bus grant, active low
BGACK_IN_  in  1  another master holds the bus, active low
AS_IN_  in  1  bus AS_ from the current master, active low
DSACK_  in  2  {DSACK1_,DSACK0_}, active low
STERM_  in  1  synchronous termination, active low
BERR_  in  1  bus error, active low
BR_  out  1  bus request
BGACK_  out  1  bus grant acknowledge
ADDR_OE  out  1  enables address/size/R_W drivers
AS_  out  1  address strobe
DS_  out  1  data strobe
R_W  out  1  1 = read
SIZE  out  2  00 = long, 10 = word
A1  out  1  word half select
DATA_LATCH  out  1  1-clk pulse; read data valid or write data taken
NEXT_LW  out  1  1-clk pulse; longword complete, advance FIFO/address
REMAIN  out  4  longwords left in the run
DMA_DONE  out  1  1-clk pulse; run completed
BUS_ERR  out  1  1-clk pulse; run aborted on BERR_ or timeout

Behaviour:
- Reset (RST high at an edge):
  - State goes to IDLE.
  - BR_, BGACK_, AS_, DS_ = 1. R_W = 1. ADDR_OE = 0. SIZE = 00. A1 = 0.
  - Pulses = 0. REMAIN = 0. Timeout counter = 0.
  - Applies mid-cycle as well: all strobes negate on the very next edge.
- IDLE: DMA_REQ=1 and XFER_CNT!=0 → REQ. Latch REMAIN=XFER_CNT and DIR_RD; BR_=0.
- REQ: move to ADDR when BG_=0, BGACK_IN_=1, AS_IN_=1, DSACK_=11 and STERM_=1. On that transition BGACK_=0 and BR_=1. DMA_REQ dropping in REQ → IDLE with BR_=1 and no pulse.
- ADDR (1 clk):
  - ADDR_OE=1, R_W=DIR_RD.
  - SIZE=00, A1=0 for the first half; SIZE=10, A1=1 for the second half.
  - Next state: STRB.
- STRB: AS_=0. DS_=0 in the same clock for reads, one clock later for writes. Then → WAIT.
- WAIT: termination priority is BERR_ > STERM_ > DSACK_ > timeout; inputs are sampled each edge.
  - BERR_=0: → ABORT.
  - STERM_=0: DATA_LATCH this clock → TERM.
  - DSACK_=00: one settle clock (SETTLE), then DATA_LATCH → TERM.
  - DSACK_=01 (DSACK1_ only, 16-bit port): SETTLE, then DATA_LATCH. First half → TERM with HALF flag set. Second half → TERM as a full longword.
  - DSACK_=10: treated as 00.
  - Timeout counter is cleared on entering WAIT and counts in WAIT/SETTLE. Reaching TIMEOUT_CYC → ABORT.
- TERM: AS_=DS_=1, ADDR_OE stays 1.
  - HALF flag set: wait for DSACK_=11 and STERM_=1, then → ADDR for the second half (bus kept).
  - Otherwise: NEXT_LW pulse, REMAIN decrements, clear HALF. Then, once DSACK_=11 and STERM_=1:
    - REMAIN becomes 0 → REL with DMA_DONE.
    - DMA_REQ=0 → REL without DMA_DONE; REMAIN keeps its value.
    - else → ADDR.
- ABORT: strobes negate, BUS_ERR pulse, REMAIN held → REL. ABORT always goes through REL.
- REL (1 clk): ADDR_OE=0, BGACK_=1, then → IDLE. DMA_DONE fires in REL.
- Invariants:
  - AS_ is never low while BGACK_=1.
  - DATA_LATCH fires at most once per bus cycle.
  - A new cycle never starts while DSACK_ or STERM_ is still asserted.
  - REMAIN never wraps below 0.

Test Plan:
- Read of 1 longword, STERM_ low on the first WAIT clock → BR_ low, BG_ grant, BGACK_ low. One DATA_LATCH in WAIT, then NEXT_LW, REMAIN 1→0, DMA_DONE in REL, BGACK_ high.
- Write of 3 longwords, DSACK_=00 after 2 wait clocks → 3 cycles under one BGACK_. DS_ lags AS_ by 1 clk. DATA_LATCH one clock after DSACK. DMA_DONE once; REMAIN 3,2,1,0.
- Read of 2 longwords, 16-bit port (DSACK_=01) → 4 bus cycles, SIZE/A1 = 00/0, 10/1, 00/0, 10/1. NEXT_LW exactly twice.
- BERR_ and STERM_ both low on the second longword of 4 → BERR_ wins. BUS_ERR pulse, no DATA_LATCH, REMAIN=3, BGACK_ released, no DMA_DONE.
- No termination, TIMEOUT_CYC=8 → BUS_ERR after 8 WAIT clocks. AS_ negates. DSACK_=00 asserted late on the ABORT edge is ignored.
- RST pulsed while AS_=0 in WAIT → next edge AS_=DS_=BGACK_=BR_=1, REMAIN=0, IDLE. A new DMA_REQ then runs normally.

Source files
------------

// File: rtl/cpu_bus_cycle_ctrl.sv
// DMA-master bus cycle sequencer for a 68030-style bus: arbitration, strobes and
// cycle termination on STERM_/DSACK_/BERR_, splitting longwords for 16-bit ports.
module cpu_bus_cycle_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       DMA_REQ,
  input  logic [3:0] XFER_CNT,
  input  logic       DIR_RD,
  input  logic       BG_,
  input  logic       BGACK_IN_,
  input  logic       AS_IN_,
  input  logic [1:0] DSACK_,
  input  logic       STERM_,
  input  logic       BERR_,
  output logic       BR_,
  output logic       BGACK_,
  output logic       ADDR_OE,
  output logic       AS_,
  output logic       DS_,
  output logic       R_W,
  output logic [1:0] SIZE,
  output logic       A1,
  output logic       DATA_LATCH,
  output logic       NEXT_LW,
  output logic [3:0] REMAIN,
  output logic       DMA_DONE,
  output logic       BUS_ERR
);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_ADDR, S_STRB, S_WAIT, S_SETTLE, S_TERM, S_ABORT, S_REL
  } state_e;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  state_e     state_q, state_d;
  logic       br_n_q, br_n_d, bgack_n_q, bgack_n_d, addr_oe_q, addr_oe_d;
  logic       as_n_q, as_n_d, ds_n_q, ds_n_d, r_w_q, r_w_d;
  logic [1:0] size_q, size_d;
  logic       a1_q, a1_d;
  logic       data_latch_q, data_latch_d, next_lw_q, next_lw_d;
  logic       dma_done_q, dma_done_d, bus_err_q, bus_err_d;
  logic [3:0] remain_q, remain_d;
  logic       dir_rd_q, dir_rd_d, half_q, half_d, narrow_q, narrow_d;
  logic [7:0] tmo_q, tmo_d;

  logic       bus_quiet, start_cycle, go_term, go_abort, go_rel, term_narrow;
  logic [3:0] rem_dec;

  assign bus_quiet = (DSACK_ == 2'b11) && STERM_;
  assign rem_dec   = (remain_q != 4'd0) ? remain_q - 4'd1 : 4'd0;

  always_comb begin
    // NOTE: every _d and helper flag gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    br_n_d       = br_n_q;
    bgack_n_d    = bgack_n_q;
    addr_oe_d    = addr_oe_q;
    as_n_d       = as_n_q;
    ds_n_d       = ds_n_q;
    r_w_d        = r_w_q;
    size_d       = size_q;
    a1_d         = a1_q;
    remain_d     = remain_q;
    dir_rd_d     = dir_rd_q;
    half_d       = half_q;
    narrow_d     = narrow_q;
    tmo_d        = tmo_q;
    data_latch_d = 1'b0;
    next_lw_d    = 1'b0;
    dma_done_d   = 1'b0;
    bus_err_d    = 1'b0;
    start_cycle  = 1'b0;
    go_term      = 1'b0;
    go_abort     = 1'b0;
    go_rel       = 1'b0;
    term_narrow  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (DMA_REQ && XFER_CNT != 4'd0) begin
          state_d  = S_REQ;
          br_n_d   = 1'b0;
          remain_d = XFER_CNT;
          dir_rd_d = DIR_RD;
          half_d   = 1'b0;
        end
      end
      S_REQ: begin
        if (!DMA_REQ) begin
          state_d = S_IDLE;
          br_n_d  = 1'b1;
        end else if (!BG_ && BGACK_IN_ && AS_IN_ && bus_quiet) begin
          br_n_d      = 1'b1;
          bgack_n_d   = 1'b0;
          start_cycle = 1'b1;
        end
      end
      S_ADDR: begin
        state_d = S_STRB;
        as_n_d  = 1'b0;
        ds_n_d  = ~dir_rd_q;
      end
      S_STRB: begin
        state_d = S_WAIT;
        ds_n_d  = 1'b0;
        tmo_d   = 8'd0;
      end
      S_WAIT: begin
        if (!BERR_) begin
          go_abort = 1'b1;
        end else if (!STERM_) begin
          go_term = 1'b1;
        end else if (DSACK_ != 2'b11) begin
          state_d  = S_SETTLE;
          narrow_d = (DSACK_ == 2'b01);
          tmo_d    = tmo_q + 8'd1;
        end else if (tmo_q >= TMO_LAST) begin
          go_abort = 1'b1;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_SETTLE: begin
        tmo_d = tmo_q + 8'd1;
        if (!BERR_) begin
          go_abort = 1'b1;
        end else begin
          go_term     = 1'b1;
          term_narrow = narrow_q;
        end
      end
      S_TERM: begin
        // First TERM clock of a completed longword is marked by the DATA_LATCH pulse.
        if (!half_q && data_latch_q) begin
          next_lw_d = 1'b1;
          remain_d  = rem_dec;
        end
        if (bus_quiet) begin
          if (half_q) begin
            start_cycle = 1'b1;
          end else if (remain_d == 4'd0) begin
            go_rel     = 1'b1;
            dma_done_d = 1'b1;
          end else if (!DMA_REQ) begin
            go_rel = 1'b1;
          end else begin
            start_cycle = 1'b1;
          end
        end
      end
      S_ABORT: go_rel = 1'b1;
      S_REL:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (start_cycle) begin
      state_d   = S_ADDR;
      addr_oe_d = 1'b1;
      r_w_d     = dir_rd_q;
      size_d    = half_q ? 2'b10 : 2'b00;
      a1_d      = half_q;
    end
    if (go_term) begin
      state_d      = S_TERM;
      as_n_d       = 1'b1;
      ds_n_d       = 1'b1;
      data_latch_d = 1'b1;
      half_d       = term_narrow & ~half_q;
    end
    if (go_abort) begin
      state_d   = S_ABORT;
      as_n_d    = 1'b1;
      ds_n_d    = 1'b1;
      bus_err_d = 1'b1;
      half_d    = 1'b0;
    end
    if (go_rel) begin
      state_d   = S_REL;
      addr_oe_d = 1'b0;
      bgack_n_d = 1'b1;
      r_w_d     = 1'b1;
      size_d    = 2'b00;
      a1_d      = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every flop captures pre-edge values regardless of statement order.
    if (RST) begin
      state_q      <= S_IDLE;
      br_n_q       <= 1'b1;
      bgack_n_q    <= 1'b1;
      addr_oe_q    <= 1'b0;
      as_n_q       <= 1'b1;
      ds_n_q       <= 1'b1;
      r_w_q        <= 1'b1;
      size_q       <= 2'b00;
      a1_q         <= 1'b0;
      data_latch_q <= 1'b0;
      next_lw_q    <= 1'b0;
      dma_done_q   <= 1'b0;
      bus_err_q    <= 1'b0;
      remain_q     <= 4'd0;
      dir_rd_q     <= 1'b0;
      half_q       <= 1'b0;
      narrow_q     <= 1'b0;
      tmo_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      br_n_q       <= br_n_d;
      bgack_n_q    <= bgack_n_d;
      addr_oe_q    <= addr_oe_d;
      as_n_q       <= as_n_d;
      ds_n_q       <= ds_n_d;
      r_w_q        <= r_w_d;
      size_q       <= size_d;
      a1_q         <= a1_d;
      data_latch_q <= data_latch_d;
      next_lw_q    <= next_lw_d;
      dma_done_q   <= dma_done_d;
      bus_err_q    <= bus_err_d;
      remain_q     <= remain_d;
      dir_rd_q     <= dir_rd_d;
      half_q       <= half_d;
      narrow_q     <= narrow_d;
      tmo_q        <= tmo_d;
    end
  end

  assign BR_        = br_n_q;
  assign BGACK_     = bgack_n_q;
  assign ADDR_OE    = addr_oe_q;
  assign AS_        = as_n_q;
  assign DS_        = ds_n_q;
  assign R_W        = r_w_q;
  assign SIZE       = size_q;
  assign A1         = a1_q;
  assign DATA_LATCH = data_latch_q;
  assign NEXT_LW    = next_lw_q;
  assign REMAIN     = remain_q;
  assign DMA_DONE   = dma_done_q;
  assign BUS_ERR    = bus_err_q;

endmodule

// File: tb/tb_cpu_bus_cycle_ctrl.sv
// Directed bench for cpu_bus_cycle_ctrl: a scripted bus slave/arbiter plus a
// negedge monitor, with hand-computed expectations for each run.
module tb_cpu_bus_cycle_ctrl;

  localparam int M_NONE  = 0;
  localparam int M_STERM = 1;
  localparam int M_D32   = 2;
  localparam int M_D16   = 3;

  logic       CLK = 1'b0;
  logic       RST, DMA_REQ, DIR_RD, BG_, BGACK_IN_, AS_IN_, STERM_, BERR_;
  logic [3:0] XFER_CNT;
  logic [1:0] DSACK_;
  logic       BR_, BGACK_, ADDR_OE, AS_, DS_, R_W, A1;
  logic       DATA_LATCH, NEXT_LW, DMA_DONE, BUS_ERR;
  logic [1:0] SIZE;
  logic [3:0] REMAIN;

  cpu_bus_cycle_ctrl #(.TIMEOUT_CYC(8)) dut (
    .CLK(CLK), .RST(RST), .DMA_REQ(DMA_REQ), .XFER_CNT(XFER_CNT), .DIR_RD(DIR_RD),
    .BG_(BG_), .BGACK_IN_(BGACK_IN_), .AS_IN_(AS_IN_), .DSACK_(DSACK_),
    .STERM_(STERM_), .BERR_(BERR_), .BR_(BR_), .BGACK_(BGACK_), .ADDR_OE(ADDR_OE),
    .AS_(AS_), .DS_(DS_), .R_W(R_W), .SIZE(SIZE), .A1(A1), .DATA_LATCH(DATA_LATCH),
    .NEXT_LW(NEXT_LW), .REMAIN(REMAIN), .DMA_DONE(DMA_DONE), .BUS_ERR(BUS_ERR)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Scripted slave: terminates once AS_ has been low 2+resp_wait samples.
  int   resp_mode  = M_NONE;
  int   resp_wait  = 0;
  int   berr_cyc   = -1;
  bit   late_dsack = 1'b0;
  int   as_cnt     = 0;
  int   cyc        = 0;
  logic rs_as_prev = 1'b1;

  initial begin : responder
    BG_ = 1'b1; STERM_ = 1'b1; DSACK_ = 2'b11; BERR_ = 1'b1;
    forever begin
      @(posedge CLK);
      #2;
      BG_ = BR_;
      if (!AS_ && rs_as_prev) cyc++;
      as_cnt     = AS_ ? 0 : as_cnt + 1;
      rs_as_prev = AS_;
      STERM_ = 1'b1; DSACK_ = 2'b11; BERR_ = 1'b1;
      if (as_cnt >= 2 + resp_wait) begin
        case (resp_mode)
          M_STERM: STERM_ = 1'b0;
          M_D32:   DSACK_ = 2'b00;
          M_D16:   DSACK_ = 2'b01;
          default: ;
        endcase
        if (cyc == berr_cyc) begin
          BERR_  = 1'b0;
          STERM_ = 1'b0;
        end
      end
      if (late_dsack && BUS_ERR) DSACK_ = 2'b00;
    end
  end

  // Monitor: event counters and per-cycle logs sampled on the falling edge.
  int   n_latch = 0, n_next = 0, n_done = 0, n_berr = 0, n_cyc = 0, n_rel = 0, n_viol = 0;
  int   as_run = 0, last_as_len = 0, ds_lag = -1;
  int   rem_log[16];
  int   sz_log[16];
  logic as_prev = 1'b1, ds_prev = 1'b1, bgack_prev = 1'b1;

  always @(negedge CLK) begin
    as_prev    <= AS_;
    ds_prev    <= DS_;
    bgack_prev <= BGACK_;
    if (DATA_LATCH) n_latch <= n_latch + 1;
    if (NEXT_LW) begin
      rem_log[n_next[3:0]] <= int'(REMAIN);
      n_next <= n_next + 1;
    end
    if (DMA_DONE) n_done <= n_done + 1;
    if (BUS_ERR)  n_berr <= n_berr + 1;
    if (!AS_ && as_prev) begin
      sz_log[n_cyc[3:0]] <= int'({SIZE, A1});
      n_cyc <= n_cyc + 1;
    end
    if (!DS_ && ds_prev && !AS_) ds_lag <= as_run;
    if (!AS_) as_run <= as_run + 1;
    else begin
      if (as_run != 0) last_as_len <= as_run;
      as_run <= 0;
    end
    if (BGACK_ && !bgack_prev) n_rel <= n_rel + 1;
    if (!AS_ && BGACK_) n_viol <= n_viol + 1;
  end

  int b_latch, b_next, b_done, b_berr, b_cyc, b_rel;

  task automatic run_xfer(input int cnt, input bit rd, input int mode, input int wt);
    int waited;
    b_latch = n_latch; b_next = n_next; b_done = n_done;
    b_berr  = n_berr;  b_cyc  = n_cyc;  b_rel  = n_rel;
    resp_mode = mode;
    resp_wait = wt;
    XFER_CNT  = 4'(cnt);
    DIR_RD    = rd;
    DMA_REQ   = 1'b1;
    waited    = 0;
    while (!(DMA_DONE || BUS_ERR) && waited < 300) begin
      tick();
      waited++;
    end
    check("run_terminates", 32'(waited < 300), 32'd1);
    DMA_REQ  = 1'b0;
    XFER_CNT = 4'd0;
    repeat (4) tick();
  endtask

  initial begin : main
    int waited;
    RST = 1'b1; DMA_REQ = 1'b0; XFER_CNT = 4'd0; DIR_RD = 1'b0;
    BGACK_IN_ = 1'b1; AS_IN_ = 1'b1;
    tick(); tick();
    check("rst_outs", 32'({BR_, BGACK_, ADDR_OE, AS_, DS_, R_W, SIZE, A1}), 32'b1_1_0_1_1_1_00_0);
    check("rst_pulses", 32'({DATA_LATCH, NEXT_LW, DMA_DONE, BUS_ERR}), 32'd0);
    check("rst_remain", 32'(REMAIN), 32'd0);
    RST = 1'b0;
    tick();

    // Read of one longword, STERM_ on the first WAIT clock, traced edge by edge.
    resp_mode = M_STERM; resp_wait = 0;
    XFER_CNT = 4'd1; DIR_RD = 1'b1; DMA_REQ = 1'b1;
    tick();
    check("s1_br_low", 32'(BR_), 32'd0);
    check("s1_remain_load", 32'(REMAIN), 32'd1);
    tick();
    check("s1_granted", 32'({BGACK_, BR_, ADDR_OE, R_W, SIZE, A1}), 32'b0_1_1_1_00_0);
    tick();
    check("s1_strobes", 32'({AS_, DS_}), 32'b00);
    tick();
    check("s1_wait_as", 32'(AS_), 32'd0);
    tick();
    check("s1_latch", 32'({DATA_LATCH, NEXT_LW, AS_, DS_}), 32'b1_0_1_1);
    tick();
    check("s1_rel", 32'({DATA_LATCH, NEXT_LW, DMA_DONE, BGACK_, ADDR_OE}), 32'b0_1_1_1_0);
    check("s1_remain_zero", 32'(REMAIN), 32'd0);
    DMA_REQ = 1'b0; XFER_CNT = 4'd0;
    tick();
    check("s1_idle", 32'({DMA_DONE, BR_, BGACK_}), 32'b0_1_1);
    repeat (2) tick();

    // Write of three longwords on a 32-bit port, DSACK_=00 after wait states.
    run_xfer(3, 1'b0, M_D32, 2);
    check("s2_cycles", 32'(n_cyc - b_cyc), 32'd3);
    check("s2_latches", 32'(n_latch - b_latch), 32'd3);
    check("s2_next_lw", 32'(n_next - b_next), 32'd3);
    check("s2_done", 32'(n_done - b_done), 32'd1);
    check("s2_one_bgack", 32'(n_rel - b_rel), 32'd1);
    check("s2_rem0", 32'(rem_log[(b_next + 0) % 16]), 32'd2);
    check("s2_rem1", 32'(rem_log[(b_next + 1) % 16]), 32'd1);
    check("s2_rem2", 32'(rem_log[(b_next + 2) % 16]), 32'd0);
    check("s2_ds_lag", 32'(ds_lag), 32'd1);

    // Read of two longwords from a 16-bit port.
    run_xfer(2, 1'b1, M_D16, 0);
    check("s3_cycles", 32'(n_cyc - b_cyc), 32'd4);
    check("s3_sz0", 32'(sz_log[(b_cyc + 0) % 16]), 32'b00_0);
    check("s3_sz1", 32'(sz_log[(b_cyc + 1) % 16]), 32'b10_1);
    check("s3_sz2", 32'(sz_log[(b_cyc + 2) % 16]), 32'b00_0);
    check("s3_sz3", 32'(sz_log[(b_cyc + 3) % 16]), 32'b10_1);
    check("s3_next_lw", 32'(n_next - b_next), 32'd2);
    check("s3_latches", 32'(n_latch - b_latch), 32'd4);
    check("s3_done", 32'(n_done - b_done), 32'd1);
    check("s3_ds_lag", 32'(ds_lag), 32'd0);

    // BERR_ together with STERM_ on the second of four longwords.
    berr_cyc = cyc + 2;
    run_xfer(4, 1'b1, M_STERM, 0);
    berr_cyc = -1;
    check("s4_bus_err", 32'(n_berr - b_berr), 32'd1);
    check("s4_latches", 32'(n_latch - b_latch), 32'd1);
    check("s4_remain", 32'(REMAIN), 32'd3);
    check("s4_no_done", 32'(n_done - b_done), 32'd0);
    check("s4_bgack_rel", 32'(BGACK_), 32'd1);

    // No termination: timeout abort, late DSACK_ on the abort edge ignored.
    late_dsack = 1'b1;
    run_xfer(1, 1'b0, M_NONE, 0);
    late_dsack = 1'b0;
    check("s5_bus_err", 32'(n_berr - b_berr), 32'd1);
    check("s5_as_len", 32'(last_as_len), 32'd9);
    check("s5_no_latch", 32'(n_latch - b_latch), 32'd0);
    check("s5_one_cycle", 32'(n_cyc - b_cyc), 32'd1);
    check("s5_remain", 32'(REMAIN), 32'd1);
    check("s5_no_done", 32'(n_done - b_done), 32'd0);

    // Reset asserted mid-cycle while AS_ is low in WAIT.
    resp_mode = M_NONE;
    XFER_CNT = 4'd3; DIR_RD = 1'b1; DMA_REQ = 1'b1;
    waited = 0;
    while (!(!AS_ && !DS_) && waited < 50) begin
      tick();
      waited++;
    end
    check("s6_reached_wait", 32'(waited < 50), 32'd1);
    tick(); tick();
    RST = 1'b1; DMA_REQ = 1'b0; XFER_CNT = 4'd0;
    tick();
    check("s6_strobes_neg", 32'({AS_, DS_, BGACK_, BR_, ADDR_OE}), 32'b1_1_1_1_0);
    check("s6_remain", 32'(REMAIN), 32'd0);
    RST = 1'b0;
    repeat (2) tick();
    run_xfer(2, 1'b1, M_STERM, 1);
    check("s6_rerun_done", 32'(n_done - b_done), 32'd1);
    check("s6_rerun_next", 32'(n_next - b_next), 32'd2);
    check("s6_rerun_remain", 32'(REMAIN), 32'd0);

    check("as_under_bgack", 32'(n_viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
